cone_vector_sequencer: RTL and testbench

- Sequences stimulus vectors into one combinational logic cone, such as a PLA-derived benchmark with 35 inputs and 14 outputs.
- Registers each accepted vector onto the cone inputs and waits a programmable number of settle cycles.
- Captures the cone outputs and reports the output toggle count (Hamming distance to the previous capture) as a switching-activity proxy for power-aware synthesis evaluation.
- Also maintains a saturating running toggle total.

---
 rtl/cone_vector_sequencer_pkg.sv | 18 +
 rtl/cone_vector_sequencer_popcount_tree.sv | 41 ++++
 rtl/cone_vector_sequencer.sv | 124 ++++++++++++
 tb/tb_cone_vector_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cone_vector_sequencer_pkg.sv
// Shared definitions for the cone vector sequencer.
// Holds the default cone/accumulator widths, the derived toggle-count width
// and the sequencer state encoding.
package cone_vector_sequencer_pkg;

  localparam int unsigned DEF_IN_W  = 35;
  localparam int unsigned DEF_OUT_W = 14;
  localparam int unsigned DEF_ACC_W = 24;
  localparam int unsigned DEF_TOG_W = $clog2(DEF_OUT_W + 1);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETTLE  = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_REPORT  = 2'd3;

endpackage

// File: rtl/cone_vector_sequencer_popcount_tree.sv
// popcount_tree: purely combinational population count built as a balanced
// adder tree by recursive halving.
// Ports:
//   i_vec  in  W             bits to count
//   o_cnt  out clog2(W+1)    number of set bits in i_vec
module popcount_tree #(
  parameter int unsigned W = 14,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_vec,
  output logic [CW-1:0] o_cnt
);

  generate
    if (W == 1) begin : g_leaf
      assign o_cnt = i_vec;
    end else begin : g_node
      localparam int unsigned LW  = W / 2;
      localparam int unsigned HW  = W - LW;
      localparam int unsigned LCW = $clog2(LW + 1);
      localparam int unsigned HCW = $clog2(HW + 1);

      logic [LCW-1:0] w_lo;
      logic [HCW-1:0] w_hi;

      popcount_tree #(.W(LW)) u_lo (
        .i_vec (i_vec[LW-1:0]),
        .o_cnt (w_lo)
      );

      popcount_tree #(.W(HW)) u_hi (
        .i_vec (i_vec[W-1:LW]),
        .o_cnt (w_hi)
      );

      // Each half count is at most W, so CW bits always hold the sum.
      assign o_cnt = CW'(w_lo) + CW'(w_hi);
    end
  endgenerate

endmodule

// File: rtl/cone_vector_sequencer.sv
// cone_vector_sequencer: drives stimulus vectors into a combinational cone,
// holds them for SETTLE cycles, captures the cone outputs and reports the
// Hamming distance to the previous capture plus a saturating running total.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_in_valid/o_in_ready    stimulus handshake, i_in_vec stimulus vector
//   o_cut_in / i_cut_out     registered cone drive / cone response
//   o_res_valid/i_res_ready  result handshake
//   o_res_vec, o_res_tog     captured outputs and their toggle count
//   o_acc_tog                saturating toggle total, i_clr_acc clears it
//   o_busy                   high outside IDLE
module cone_vector_sequencer
  import cone_vector_sequencer_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  localparam int unsigned TOG_W = $clog2(OUT_W + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_vec,
  output logic [IN_W-1:0]  o_cut_in,
  input  logic [OUT_W-1:0] i_cut_out,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [OUT_W-1:0] o_res_vec,
  output logic [TOG_W-1:0] o_res_tog,
  output logic [ACC_W-1:0] o_acc_tog,
  input  logic             i_clr_acc,
  output logic             o_busy
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [IN_W-1:0]  r_cut_in;
  logic [OUT_W-1:0] r_res_vec;
  logic [TOG_W-1:0] r_res_tog;
  logic [ACC_W-1:0] r_acc_tog;
  logic [OUT_W-1:0] r_prev_cap;
  logic             r_res_valid;

  logic [OUT_W-1:0] w_diff;
  logic [TOG_W-1:0] w_pop;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W:0]   w_acc_sum;
  logic [ACC_W-1:0] w_acc_next;

  assign w_diff = i_cut_out ^ r_prev_cap;

  popcount_tree #(.W(OUT_W)) u_popcount (
    .i_vec (w_diff),
    .o_cnt (w_pop)
  );

  // A clear coinciding with a capture restarts the total from this capture.
  assign w_acc_base = i_clr_acc ? '0 : r_acc_tog;
  assign w_acc_sum  = {1'b0, w_acc_base} + (ACC_W + 1)'(w_pop);
  assign w_acc_next = w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cut_in    <= '0;
      r_res_vec   <= '0;
      r_res_tog   <= '0;
      r_acc_tog   <= '0;
      r_prev_cap  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_cut_in <= i_in_vec;
            r_cnt    <= SETTLE_INIT;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_CAPTURE: begin
          r_res_vec   <= i_cut_out;
          r_res_tog   <= w_pop;
          r_prev_cap  <= i_cut_out;
          r_acc_tog   <= w_acc_next;
          r_res_valid <= 1'b1;
          r_state     <= ST_REPORT;
        end
        ST_REPORT: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (i_clr_acc && (r_state != ST_CAPTURE)) begin
        r_acc_tog  <= '0;
        r_prev_cap <= '0;
      end
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_cut_in    = r_cut_in;
  assign o_res_valid = r_res_valid;
  assign o_res_vec   = r_res_vec;
  assign o_res_tog   = r_res_tog;
  assign o_acc_tog   = r_acc_tog;

endmodule

// File: tb/tb_cone_vector_sequencer.sv
// Directed bench for cone_vector_sequencer. Two instances share all inputs:
// the default-width one and an ACC_W=4 one for saturation. The cone model is
// cut_out = cut_in[13:0].
module tb_cone_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [34:0] in_vec;
  logic        res_ready;
  logic        clr_acc;

  logic        in_ready, res_valid, busy;
  logic [34:0] cut_in;
  logic [13:0] cut_out, res_vec;
  logic [3:0]  res_tog;
  logic [23:0] acc_tog;

  logic        s_in_ready, s_res_valid, s_busy;
  logic [34:0] s_cut_in;
  logic [13:0] s_cut_out, s_res_vec;
  logic [3:0]  s_res_tog;
  logic [3:0]  s_acc_tog;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign cut_out   = cut_in[13:0];
  assign s_cut_out = s_cut_in[13:0];

  cone_vector_sequencer #(.IN_W(35), .OUT_W(14), .SETTLE(2), .ACC_W(24)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_vec    (in_vec),
    .o_cut_in    (cut_in),
    .i_cut_out   (cut_out),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_vec   (res_vec),
    .o_res_tog   (res_tog),
    .o_acc_tog   (acc_tog),
    .i_clr_acc   (clr_acc),
    .o_busy      (busy)
  );

  cone_vector_sequencer #(.IN_W(35), .OUT_W(14), .SETTLE(2), .ACC_W(4)) u_dut_sat (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (s_in_ready),
    .i_in_vec    (in_vec),
    .o_cut_in    (s_cut_in),
    .i_cut_out   (s_cut_out),
    .o_res_valid (s_res_valid),
    .i_res_ready (res_ready),
    .o_res_vec   (s_res_vec),
    .o_res_tog   (s_res_tog),
    .o_acc_tog   (s_acc_tog),
    .i_clr_acc   (clr_acc),
    .o_busy      (s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cut_in"},    cut_in,    0);
    chk({tag, "_res_vec"},   res_vec,   0);
    chk({tag, "_res_tog"},   res_tog,   0);
    chk({tag, "_acc_tog"},   acc_tog,   0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_in_ready"},  in_ready,  1);
    chk({tag, "_acc4"},      s_acc_tog, 0);
  endtask

  // Called at the negedge of the handshake cycle (in_valid && in_ready seen).
  task automatic wait_result(input string tag, input logic [13:0] e_vec, input int e_tog,
                             input int e_acc, input int e_acc4);
    int lat;
    int bad_rdy;
    lat     = 0;
    bad_rdy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid = 1'b0;
      if (in_ready) bad_rdy++;
    end while (!res_valid && lat < 50);
    chk({tag, "_latency"},  lat,       4);
    chk({tag, "_rdy_low"},  bad_rdy,   0);
    chk({tag, "_res_vec"},  res_vec,   e_vec);
    chk({tag, "_res_tog"},  res_tog,   e_tog);
    chk({tag, "_acc_tog"},  acc_tog,   e_acc);
    chk({tag, "_acc4"},     s_acc_tog, e_acc4);
    if (res_ready) begin
      @(negedge clk);
      chk({tag, "_done_valid"}, res_valid, 0);
      chk({tag, "_done_ready"}, in_ready,  1);
    end
  endtask

  task automatic run_vec(input string tag, input logic [34:0] v, input logic [13:0] e_vec,
                         input int e_tog, input int e_acc, input int e_acc4);
    int n;
    @(negedge clk);
    in_vec   = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, in_ready, 1);
    wait_result(tag, e_vec, e_tog, e_acc, e_acc4);
  endtask

  task automatic pulse_clr(input string tag);
    @(negedge clk);
    clr_acc = 1'b1;
    @(negedge clk);
    clr_acc = 1'b0;
    chk({tag, "_acc"},  acc_tog,   0);
    chk({tag, "_acc4"}, s_acc_tog, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    res_ready = 1'b1;
    clr_acc   = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;

    run_vec("A", 35'h0000_3FFF, 14'h3FFF, 14, 14, 14);
    run_vec("B", 35'h0000_0F0F, 14'h0F0F, 6, 20, 15);

    // Hold the result in REPORT and offer a competing vector.
    res_ready = 1'b0;
    run_vec("C", 35'h0000_00FF, 14'h00FF, 8, 28, 15);
    in_vec   = 35'h0000_2AAA;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_vec !== 14'h00FF || res_tog !== 4'd8 ||
          in_ready !== 1'b0 || cut_in !== 35'h0000_00FF) bad++;
    end
    chk("C_stall", bad, 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("C_release_ready", in_ready,  1);
    chk("C_release_valid", res_valid, 0);
    chk("C_release_cut",   cut_in,    35'h0000_00FF);
    wait_result("D", 14'h2AAA, 7, 35, 15);

    pulse_clr("clr1");
    run_vec("E", 35'h0000_0001, 14'h0001, 1, 1, 1);

    // Abort a vector in SETTLE with an asynchronous reset.
    @(negedge clk);
    in_vec   = 35'h4_0000_1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("R_cut_in", cut_in, 35'h4_0000_1234);
    chk("R_busy",   busy,   1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("R_async");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("F", 35'h0000_3FFF, 14'h3FFF, 14, 14, 14);

    // Alternate full/empty outputs to drive the 4-bit total into saturation.
    pulse_clr("clr2");
    run_vec("G", 35'h0000_3FFF, 14'h3FFF, 14, 14, 14);
    run_vec("H", 35'h0000_0000, 14'h0000, 14, 28, 15);
    run_vec("I", 35'h0000_3FFF, 14'h3FFF, 14, 42, 15);
    run_vec("J", 35'h0000_0000, 14'h0000, 14, 56, 15);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
